mnist_argmax: RTL
=================

Name: mnist_argmax

Overview:
Classification back-end placed directly downstream of the MNIST accelerator. Captures the ten signed class scores (result0..result9) on a start pulse and scans them sequentially, one class per cycle. Reports the predicted digit, the winning score, and the margin between the top two scores over a valid/ready handshake. Also keeps a running count of completed classifications.

Parameters:
DATA_W, 32, width of each signed class score
CNT_W, 16, width of the classification counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears block on next rising edge)
start  input  1  one-cycle pulse: result0..result9 are valid this cycle
result0..result9  input  DATA_W each  signed class scores from accelerator
busy  output  1  high from accepted start until output handshake completes
out_valid  output  1  classification result available
out_ready  input  1  consumer accepts result
digit  output  4  predicted class 0..9
max_score  output  DATA_W  signed winning score
margin  output  DATA_W+1  unsigned (best - second best)
class_count  output  CNT_W  number of completed handshakes

Behaviour:
- Reset (reset==0 at rising edge): state IDLE; busy=0, out_valid=0, digit=0, max_score=0, margin=0, class_count=0; all score registers cleared. Reset has priority over every other event, including mid-scan and mid-handshake.
- States: IDLE, SCAN, OUT.
- IDLE:
  - start==1 at edge N: latch all ten scores into internal registers.
  - Set best=result0, best_idx=0, second=most-negative (-2^(DATA_W-1)), idx=1.
  - Go to SCAN, busy=1.
- SCAN (edges N+1..N+9), one latched score s[idx] per edge:
  - if s > best: second=best; best=s; best_idx=idx.
  - else if s > second: second=s.
  - Signed compares throughout.
  - Strict greater-than, so ties resolve to the lowest index. A tie with best places the tied value in second (margin 0).
  - At edge N+9 (idx==9): go to OUT; out_valid=1; digit=best_idx; max_score=best; margin=best-second, computed in DATA_W+1 bits (never overflows, never negative).
  - Latency: out_valid visible 9 cycles after the edge that sampled start.
- OUT:
  - digit, max_score and margin are held stable while out_valid==1 and out_ready==0.
  - Handshake at edge where out_valid&&out_ready: class_count+=1 (wraps all-ones -> 0); out_valid=0.
  - If start==1 on that same edge: latch new scores and enter SCAN directly (busy stays 1). Otherwise go to IDLE, busy=0.
- start in SCAN, or in OUT without out_ready: ignored, no error.
- result inputs are sampled only on the accepted start edge; later changes have no effect on the run in progress.
- digit, max_score and margin keep their last values after the handshake, until the next run completes.
- out_ready while out_valid==0: no effect.

Test Plan:
1. result_i = 10*i (0..90), start, out_ready=1 -> out_valid rises 9 cycles after start; digit=9, max_score=90, margin=10, class_count=1, busy drops next cycle.
2. result3=result7=500, all others -5 -> digit=3, max_score=500, margin=0.
3. result_i = -100-i -> digit=0, max_score=-100, margin=1. Then result4=0x7FFFFFFF, others 0x80000000 -> digit=4, margin=33'h0_FFFF_FFFF.
4. out_ready=0 for 5 cycles after out_valid; pulse start during SCAN and during OUT wait; change result inputs -> outputs stable, starts ignored, scores unaffected. Then out_ready=1 with start=1 on the same edge -> class_count increments, new run completes 9 cycles later with new-input result.
5. Drive reset=0 on the 4th SCAN cycle -> next edge all outputs at reset values, state IDLE. A subsequent start produces a correct result with class_count=1.
6. Bench with CNT_W=4: 17 back-to-back classifications -> class_count sequence wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/mnist_argmax.sv
// Argmax back-end for the MNIST accelerator: latches ten signed class scores,
// scans one per cycle, and returns digit, winning score and top-two margin.
module mnist_argmax #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] result0,
  input  logic [DATA_W-1:0] result1,
  input  logic [DATA_W-1:0] result2,
  input  logic [DATA_W-1:0] result3,
  input  logic [DATA_W-1:0] result4,
  input  logic [DATA_W-1:0] result5,
  input  logic [DATA_W-1:0] result6,
  input  logic [DATA_W-1:0] result7,
  input  logic [DATA_W-1:0] result8,
  input  logic [DATA_W-1:0] result9,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        digit,
  output logic [DATA_W-1:0] max_score,
  output logic [DATA_W:0]   margin,
  output logic [CNT_W-1:0]  class_count,
  output logic [1:0]        fsm_state
);

  // Handshake: a result transfers on any rising edge where out_valid && out_ready.
  // out_valid stays high and digit/max_score/margin stay stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2} state_t;

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_next;

  // Scores 1..9 queue up and shift toward slot 0; slot 0 is compared each SCAN cycle.
  logic signed [DATA_W-1:0] q [9];
  logic signed [DATA_W-1:0] best, second, best_n, second_n, cur;
  logic [3:0]               best_idx, best_idx_n, idx;
  logic [DATA_W:0]          margin_n;
  logic                     handshake, load;

  assign fsm_state = state;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign handshake = (state == OUT) && out_ready;
  assign load      = start && ((state == IDLE) || handshake);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx == 4'd9) state_next = OUT;
      OUT:     if (out_ready) state_next = start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur        = q[0];
    best_n     = best;
    second_n   = second;
    best_idx_n = best_idx;
    if (cur > best) begin
      second_n   = best;
      best_n     = cur;
      best_idx_n = idx;
    end else if (cur > second) begin
      second_n = cur;
    end
    // Sign-extend to DATA_W+1 so best - second cannot overflow.
    margin_n = {best_n[DATA_W-1], best_n} - {second_n[DATA_W-1], second_n};
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) q[i] <= '0;
      best        <= '0;
      second      <= '0;
      best_idx    <= '0;
      idx         <= '0;
      digit       <= '0;
      max_score   <= '0;
      margin      <= '0;
      class_count <= '0;
    end else begin
      if (load) begin
        q[0]     <= result1;
        q[1]     <= result2;
        q[2]     <= result3;
        q[3]     <= result4;
        q[4]     <= result5;
        q[5]     <= result6;
        q[6]     <= result7;
        q[7]     <= result8;
        q[8]     <= result9;
        best     <= result0;
        best_idx <= 4'd0;
        second   <= MOST_NEG;
        idx      <= 4'd1;
      end else if (state == SCAN) begin
        for (int i = 0; i < 8; i++) q[i] <= q[i+1];
        q[8]     <= '0;
        best     <= best_n;
        second   <= second_n;
        best_idx <= best_idx_n;
        idx      <= idx + 4'd1;
        if (idx == 4'd9) begin
          digit     <= best_idx_n;
          max_score <= best_n;
          margin    <= margin_n;
        end
      end
      if (handshake) class_count <= class_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
